memory_arbiter: RTL and testbench

Shares one unified memory port between three requesters: instruction fetch (read), executor load (read) and executor store (write). It sits in `Core` between `Fetcher`/`Executor` and the single external memory interface. Requests are granted round-robin, one transaction in flight at a time. A watchdog completes any transaction the memory does not answer within a bounded number of cycles.

---
 rtl/memory_arbiter_if.sv | 41 ++++
 rtl/memory_arbiter.sv | 135 +++++++++++++
 tb/tb_memory_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bundles the three requester ports and the shared memory port of memory_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface memory_arbiter_if;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_ready;

  logic [31:0] load_addr;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;

  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        store_valid;
  logic        store_ready;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        timed_out;

  modport slave (
    input  fetch_addr, fetch_valid, load_addr, load_valid,
    input  store_addr, store_data, store_valid, mem_rdata, mem_ready,
    output fetch_data, fetch_ready, load_data, load_ready, store_ready,
    output mem_addr, mem_wdata, mem_we, mem_valid, timed_out
  );

  modport master (
    output fetch_addr, fetch_valid, load_addr, load_valid,
    output store_addr, store_data, store_valid, mem_rdata, mem_ready,
    input  fetch_data, fetch_ready, load_data, load_ready, store_ready,
    input  mem_addr, mem_wdata, mem_we, mem_valid, timed_out
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch, load and store,
// one transaction in flight, with a watchdog that force-completes stalled accesses.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [1:0]  next_q;
  logic [1:0]  gnt_q;
  logic [31:0] cnt_q;
  logic [2:0]  ready_q;
  logic [31:0] fetch_data_q;
  logic [31:0] load_data_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;
  logic        mem_valid_q;
  logic        timed_out_q;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  logic [2:0]  req;
  logic [1:0]  cand0, cand1, cand2;
  logic [1:0]  gnt_idx;
  logic        gnt_any;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;

  assign req   = {bus.store_valid, bus.load_valid, bus.fetch_valid};
  assign cand0 = next_q;
  assign cand1 = inc3(next_q);
  assign cand2 = inc3(cand1);

  // Highest-priority candidate is checked last so it overrides the others.
  always_comb begin
    gnt_any = |req;
    gnt_idx = cand2;
    if (req[cand1]) gnt_idx = cand1;
    if (req[cand0]) gnt_idx = cand0;
  end

  always_comb begin
    sel_addr  = bus.store_addr;
    sel_wdata = bus.store_data;
    sel_we    = 1'b1;
    case (gnt_idx)
      2'd0: begin
        sel_addr  = bus.fetch_addr;
        sel_wdata = '0;
        sel_we    = 1'b0;
      end
      2'd1: begin
        sel_addr  = bus.load_addr;
        sel_wdata = '0;
        sel_we    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      next_q       <= 2'd0;
      gnt_q        <= 2'd0;
      cnt_q        <= '0;
      ready_q      <= '0;
      fetch_data_q <= '0;
      load_data_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_valid_q  <= 1'b0;
      timed_out_q  <= 1'b0;
    end else begin
      // Ready pulses and returned data live for exactly the DONE cycle.
      ready_q      <= '0;
      fetch_data_q <= '0;
      load_data_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            gnt_q       <= gnt_idx;
            next_q      <= inc3(gnt_idx);
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_we_q    <= sel_we;
            mem_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          if (bus.mem_ready) begin
            mem_valid_q    <= 1'b0;
            ready_q[gnt_q] <= 1'b1;
            if (gnt_q == 2'd0) fetch_data_q <= bus.mem_rdata;
            if (gnt_q == 2'd1) load_data_q  <= bus.mem_rdata;
            state_q        <= StDone;
          end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
            mem_valid_q    <= 1'b0;
            ready_q[gnt_q] <= 1'b1;
            timed_out_q    <= 1'b1;
            state_q        <= StDone;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.fetch_ready = ready_q[0];
  assign bus.load_ready  = ready_q[1];
  assign bus.store_ready = ready_q[2];
  assign bus.fetch_data  = fetch_data_q;
  assign bus.load_data   = load_data_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_valid   = mem_valid_q;
  assign bus.timed_out   = timed_out_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a table of single transactions plus
// hand-written sequences for arbitration order and reset during BUSY.
module tb_memory_arbiter;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_arbiter_if bus ();

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;     // BUSY cycles before mem_ready; -1 = never answer
    logic [31:0] rdata;
    logic [31:0] exp_data;
    int          exp_busy;  // cycles mem_valid stays high
    int          exp_lat;   // edges from request sampling edge to observed ready
    logic        exp_to;
  } row_t;

  row_t rows[7];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          bc = 0;
  int          mem_delay = -1;
  logic [31:0] mem_rd = '0;
  logic [2:0]  hold = '0;

  int          done_idx[$];
  int          done_cyc[$];
  int          done_busy[$];
  logic [31:0] done_data[$];
  logic [31:0] g_addr[$];
  logic [31:0] g_wdata[$];
  logic        g_we[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_valid(input int idx, input logic v);
    case (idx)
      0:       bus.fetch_valid = v;
      1:       bus.load_valid  = v;
      default: bus.store_valid = v;
    endcase
  endtask

  task automatic set_req(input int idx, input logic [31:0] addr, input logic [31:0] wdata);
    case (idx)
      0:       bus.fetch_addr = addr;
      1:       bus.load_addr  = addr;
      default: begin
        bus.store_addr = addr;
        bus.store_data = wdata;
      end
    endcase
    set_valid(idx, 1'b1);
  endtask

  task automatic clear_logs();
    done_idx.delete();
    done_cyc.delete();
    done_busy.delete();
    done_data.delete();
    g_addr.delete();
    g_wdata.delete();
    g_we.delete();
  endtask

  // One clock; observe at the falling edge, then act as requesters and memory.
  task automatic step();
    logic [2:0]  rdy;
    int          idx;
    logic [31:0] d;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rdy = {bus.store_ready, bus.load_ready, bus.fetch_ready};
    if (rdy != 3'b000) begin
      chk("ready_onehot", 32'($countones(rdy)), 32'd1);
      idx = rdy[0] ? 0 : (rdy[1] ? 1 : 2);
      d = (idx == 0) ? bus.fetch_data : ((idx == 1) ? bus.load_data : 32'h0);
      done_idx.push_back(idx);
      done_cyc.push_back(cyc);
      done_busy.push_back(bc);
      done_data.push_back(d);
      if (!hold[idx]) set_valid(idx, 1'b0);
    end
    if (!bus.fetch_ready) chk("fetch_data_zero", bus.fetch_data, 32'h0);
    if (!bus.load_ready)  chk("load_data_zero", bus.load_data, 32'h0);
    if (bus.mem_valid) begin
      if (bc == 0) begin
        g_addr.push_back(bus.mem_addr);
        g_wdata.push_back(bus.mem_wdata);
        g_we.push_back(bus.mem_we);
      end else begin
        chk("mem_addr_stable", bus.mem_addr, g_addr[$]);
        chk("mem_wdata_stable", bus.mem_wdata, g_wdata[$]);
        chk("mem_we_stable", 32'(bus.mem_we), 32'(g_we[$]));
      end
      bus.mem_ready = (mem_delay >= 0) && (bc == mem_delay);
      bus.mem_rdata = bus.mem_ready ? mem_rd : 32'hFFFF_FFFF;
      bc++;
    end else begin
      bc = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'hFFFF_FFFF;
    end
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int k = 0;
    while (done_idx.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(name, 32'(done_idx.size()), 32'(n));
  endtask

  task automatic run_row(input int i, input row_t r);
    int t0;
    clear_logs();
    mem_delay = r.delay;
    mem_rd    = r.rdata;
    hold      = '0;
    t0        = cyc;
    set_req(r.idx, r.addr, r.wdata);
    step();
    // Requester inputs wander during BUSY; the memory side must not follow.
    case (r.idx)
      0:       bus.fetch_addr = ~r.addr;
      1:       bus.load_addr  = ~r.addr;
      default: begin
        bus.store_addr = ~r.addr;
        bus.store_data = ~r.wdata;
      end
    endcase
    wait_done(1, 20, $sformatf("row%0d_done", i));
    if (done_idx.size() == 1 && g_addr.size() == 1) begin
      chk($sformatf("row%0d_idx", i), 32'(done_idx[0]), 32'(r.idx));
      chk($sformatf("row%0d_data", i), done_data[0], r.exp_data);
      chk($sformatf("row%0d_latency", i), 32'(done_cyc[0] - t0), 32'(r.exp_lat));
      chk($sformatf("row%0d_busy", i), 32'(done_busy[0]), 32'(r.exp_busy));
      chk($sformatf("row%0d_addr", i), g_addr[0], r.addr);
      chk($sformatf("row%0d_we", i), 32'(g_we[0]), 32'(r.idx == 2));
      if (r.idx == 2) chk($sformatf("row%0d_wdata", i), g_wdata[0], r.wdata);
    end
    chk($sformatf("row%0d_timed_out", i), 32'(bus.timed_out), 32'(r.exp_to));
    step();
    chk($sformatf("row%0d_idle", i), 32'(bus.mem_valid), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    bus.fetch_addr = '0;  bus.fetch_valid = 1'b0;
    bus.load_addr  = '0;  bus.load_valid  = 1'b0;
    bus.store_addr = '0;  bus.store_data  = '0;  bus.store_valid = 1'b0;
    bus.mem_rdata  = '0;  bus.mem_ready   = 1'b0;

    step();
    step();
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_fetch_ready", 32'(bus.fetch_ready), 32'h0);
    chk("rst_load_ready", 32'(bus.load_ready), 32'h0);
    chk("rst_store_ready", 32'(bus.store_ready), 32'h0);
    chk("rst_fetch_data", bus.fetch_data, 32'h0);
    chk("rst_load_data", bus.load_data, 32'h0);
    chk("rst_timed_out", 32'(bus.timed_out), 32'h0);
    reset = 1'b0;
    step();

    // Latency = delay + 2 when answered; a timeout holds mem_valid for TO cycles.
    rows[0] = '{0, 32'h100,  32'h0,        2,  32'hDEADBEEF, 32'hDEADBEEF, 3, 4, 1'b0};
    rows[1] = '{1, 32'h2000, 32'h0,        0,  32'h0BADF00D, 32'h0BADF00D, 1, 2, 1'b0};
    rows[2] = '{2, 32'h40,   32'h12345678, 1,  32'h99999999, 32'h0,        2, 3, 1'b0};
    rows[3] = '{0, 32'h104,  32'h0,        3,  32'hA5A5A5A5, 32'hA5A5A5A5, 4, 5, 1'b0};
    rows[4] = '{1, 32'h300,  32'h0,        -1, 32'h55555555, 32'h0,        4, 5, 1'b1};
    rows[5] = '{0, 32'h108,  32'h0,        1,  32'h11112222, 32'h11112222, 2, 3, 1'b1};
    rows[6] = '{2, 32'h44,   32'hCAFEF00D, 0,  32'h0,        32'h0,        1, 2, 1'b1};
    for (int i = 0; i < 7; i++) run_row(i, rows[i]);

    // All three requesting out of reset: served fetch, load, store.
    reset = 1'b1;
    set_req(0, 32'h10, 32'h0);
    set_req(1, 32'h20, 32'h0);
    set_req(2, 32'h40, 32'h12345678);
    step();
    chk("seqa_timed_out_cleared", 32'(bus.timed_out), 32'h0);
    clear_logs();
    mem_delay = 1;
    mem_rd    = 32'h0000_0A0A;
    hold      = '0;
    reset     = 1'b0;
    wait_done(3, 30, "seqa_done");
    if (done_idx.size() == 3 && g_addr.size() == 3) begin
      chk("seqa_order0", 32'(done_idx[0]), 32'd0);
      chk("seqa_order1", 32'(done_idx[1]), 32'd1);
      chk("seqa_order2", 32'(done_idx[2]), 32'd2);
      chk("seqa_fetch_addr", g_addr[0], 32'h10);
      chk("seqa_load_addr", g_addr[1], 32'h20);
      chk("seqa_store_addr", g_addr[2], 32'h40);
      chk("seqa_store_wdata", g_wdata[2], 32'h12345678);
      chk("seqa_store_we", 32'(g_we[2]), 32'h1);
      chk("seqa_fetch_we", 32'(g_we[0]), 32'h0);
    end
    step();

    // Fetch and load held high: grants alternate, back to back every 3 cycles.
    clear_logs();
    mem_delay = 0;
    hold      = 3'b011;
    set_req(0, 32'h500, 32'h0);
    set_req(1, 32'h600, 32'h0);
    wait_done(4, 40, "seqb_done");
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    hold = '0;
    if (done_idx.size() == 4 && g_addr.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("seqb_order%0d", k), 32'(done_idx[k]), 32'(k % 2));
        chk($sformatf("seqb_addr%0d", k), g_addr[k], (k % 2 == 0) ? 32'h500 : 32'h600);
      end
      chk("seqb_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd3);
    end
    step();
    chk("seqb_idle", 32'(bus.mem_valid), 32'h0);

    // Reset during a store's BUSY abandons it with no ready pulse.
    clear_logs();
    mem_delay = -1;
    set_req(2, 32'h80, 32'hFEEDFACE);
    step();
    step();
    chk("seqc_busy_valid", 32'(bus.mem_valid), 32'h1);
    chk("seqc_busy_we", 32'(bus.mem_we), 32'h1);
    reset = 1'b1;
    set_valid(2, 1'b0);
    step();
    chk("seqc_rst_mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("seqc_rst_mem_addr", bus.mem_addr, 32'h0);
    chk("seqc_rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("seqc_rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("seqc_rst_store_ready", 32'(bus.store_ready), 32'h0);
    chk("seqc_rst_timed_out", 32'(bus.timed_out), 32'h0);
    reset = 1'b0;
    step();
    step();
    chk("seqc_no_ready", 32'(done_idx.size()), 32'h0);
    clear_logs();
    mem_delay = 1;
    mem_rd    = 32'h0000_0077;
    set_req(0, 32'h900, 32'h0);
    wait_done(1, 20, "seqc_fetch_done");
    if (done_idx.size() == 1 && g_addr.size() == 1) begin
      chk("seqc_fetch_idx", 32'(done_idx[0]), 32'd0);
      chk("seqc_fetch_data", done_data[0], 32'h0000_0077);
      chk("seqc_fetch_addr", g_addr[0], 32'h900);
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
